// File: rtl/memarb_pkg.sv
// rtl/memarb_pkg.sv - shared types and constants for the mem_arbiter slice
package memarb_pkg;

    // Arbiter sequencing: normal per-cycle arbitration, or the write half of a read-modify-write.
    typedef enum logic {
        ST_IDLE,
        ST_RMW
    } state_t;

    // Which port owns the SRAM read data returning this cycle.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [3:0] BE_FULL      = 4'hF;
    localparam int         STARVE_CNT_W = 4;

endpackage

// File: rtl/memarb_byte_merge.sv
// rtl/memarb_byte_merge.sv - byte-lane merge of an old word with new store data
//
// Ports:
//   old_word  in  32  word read back from the SRAM
//   new_word  in  32  store data, byte lanes aligned
//   be        in  4   byte enables, bit k selects new_word byte k
//   merged    out 32  combined word
module memarb_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port word SRAM with RMW for partial stores
//
// Optional feature macro: MEMARB_PERF_EN adds perf_i_stall, perf_d_stall, perf_rmw counters.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   i_req/i_addr               fetch request and byte address
//   i_gnt/i_rvalid/i_rdata     fetch accept, read data valid, read data
//   d_req/d_we/d_be/d_addr/d_wdata   data request, store flag, byte enables, address, store data
//   d_gnt/d_rvalid/d_rdata     data accept, load data valid, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   SRAM strobe, write, word address, data in/out
module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int MEM_AW     = 11,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]       perf_i_stall,
    output logic [31:0]       perf_d_stall,
    output logic [31:0]       perf_rmw
`endif
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

    state_t                  state_q, state_d;
    owner_t                  owner_q, owner_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic [MEM_AW-1:0]       rmw_addr_q, rmw_addr_d;
    logic [3:0]              rmw_be_q, rmw_be_d;
    logic [31:0]             rmw_wdata_q, rmw_wdata_d;

    logic              fetch_wins;
    logic              i_gnt_int;
    logic              d_gnt_int;
    logic              d_partial;
    logic [MEM_AW-1:0] i_idx;
    logic [MEM_AW-1:0] d_idx;
    logic [31:0]       merged_word;
    logic              unused_addr_bits;

    assign i_idx     = i_addr[MEM_AW+1:2];
    assign d_idx     = d_addr[MEM_AW+1:2];
    assign d_partial = (d_be != BE_FULL) && (d_be != 4'h0);

    // Byte offset and high address bits are deliberately ignored, so addresses wrap.
    assign unused_addr_bits = ^{i_addr[31:MEM_AW+2], i_addr[1:0], d_addr[31:MEM_AW+2], d_addr[1:0]};

    // Data normally wins; a fetch that has been refused STARVE_MAX times in a row takes the slot.
    assign fetch_wins = i_req && (!d_req || (starve_q == STARVE_LIM));
    assign i_gnt_int  = (state_q == ST_IDLE) && fetch_wins;
    assign d_gnt_int  = (state_q == ST_IDLE) && d_req && !fetch_wins;

    memarb_byte_merge u_merge (
        .old_word (mem_rdata),
        .new_word (rmw_wdata_q),
        .be       (rmw_be_q),
        .merged   (merged_word)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            rmw_addr_q  <= '0;
            rmw_be_q    <= '0;
            rmw_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_be_q    <= rmw_be_d;
            rmw_wdata_q <= rmw_wdata_d;
        end
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        owner_d     = OWN_NONE;
        rmw_addr_d  = rmw_addr_q;
        rmw_be_d    = rmw_be_q;
        rmw_wdata_d = rmw_wdata_q;

        // Keeps counting through the RMW cycle, saturating at the limit so the compare still hits.
        if (!i_req || i_gnt_int) begin
            starve_d = '0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
        end else begin
            starve_d = starve_q;
        end

        if (state_q == ST_RMW) begin
            state_d = ST_IDLE;
        end else if (i_gnt_int) begin
            owner_d = OWN_I;
        end else if (d_gnt_int) begin
            if (!d_we) begin
                owner_d = OWN_D;
            end else if (d_partial) begin
                state_d     = ST_RMW;
                rmw_addr_d  = d_idx;
                rmw_be_d    = d_be;
                rmw_wdata_d = d_wdata;
            end
        end
    end

    // Outputs; everything is forced low while Reset is high, which also aborts a pending RMW write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        if (!Reset) begin
            i_gnt = i_gnt_int;
            d_gnt = d_gnt_int;
            if (state_q == ST_RMW) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = rmw_addr_q;
                mem_wdata = merged_word;
            end else if (i_gnt_int) begin
                mem_en   = 1'b1;
                mem_addr = i_idx;
            end else if (d_gnt_int) begin
                // Loads and partial stores read; full stores write; empty stores touch nothing.
                if (!d_we || d_partial) begin
                    mem_en   = 1'b1;
                    mem_addr = d_idx;
                end else if (d_be == BE_FULL) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = d_idx;
                    mem_wdata = d_wdata;
                end
            end
        end
    end

    assign i_rvalid = !Reset && (owner_q == OWN_I);
    assign d_rvalid = !Reset && (owner_q == OWN_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

`ifdef MEMARB_PERF_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_rmw_q, perf_rmw_d;

    always_comb begin
        perf_i_d   = perf_i_q + ((i_req && !i_gnt_int) ? 32'd1 : 32'd0);
        perf_d_d   = perf_d_q + ((d_req && !d_gnt_int) ? 32'd1 : 32'd0);
        perf_rmw_d = perf_rmw_q + ((d_gnt_int && d_we && d_partial) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            perf_i_q   <= '0;
            perf_d_q   <= '0;
            perf_rmw_q <= '0;
        end else begin
            perf_i_q   <= perf_i_d;
            perf_d_q   <= perf_d_d;
            perf_rmw_q <= perf_rmw_d;
        end
    end

    assign perf_i_stall = Reset ? 32'd0 : perf_i_q;
    assign perf_d_stall = Reset ? 32'd0 : perf_d_q;
    assign perf_rmw     = Reset ? 32'd0 : perf_rmw_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        Clk;
    logic        Reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef MEMARB_PERF_EN
    logic [31:0] perf_i_stall;
    logic [31:0] perf_d_stall;
    logic [31:0] perf_rmw;
`endif

    mem_arbiter #(.MEM_AW(11), .STARVE_MAX(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEMARB_PERF_EN
        ,
        .perf_i_stall (perf_i_stall),
        .perf_d_stall (perf_d_stall),
        .perf_rmw     (perf_rmw)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model: synchronous, read data one cycle after the strobe.
    logic [31:0] sram [2048];
    logic [31:0] ref_mem [2048];
    always @(posedge Clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    always @(posedge Clk) cyc_n <= cyc_n + 1;

    // Scoreboard entries: {cycle the data is due, expected word}
    logic [63:0] iq[$];
    logic [63:0] dq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc_n, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (i_rvalid) begin
            if (iq.size() == 0) begin
                checks++; failures++;
                $display("FAIL i_rvalid_unexpected @cyc %0d", cyc_n);
            end else begin
                logic [63:0] e;
                e = iq.pop_front();
                chk("i_rvalid_cycle", cyc_n, e[63:32]);
                chk("i_rdata", i_rdata, e[31:0]);
            end
        end
        if (d_rvalid) begin
            if (dq.size() == 0) begin
                checks++; failures++;
                $display("FAIL d_rvalid_unexpected @cyc %0d", cyc_n);
            end else begin
                logic [63:0] e;
                e = dq.pop_front();
                chk("d_rvalid_cycle", cyc_n, e[63:32]);
                chk("d_rdata", d_rdata, e[31:0]);
            end
        end
    end

    function automatic logic [10:0] idx(input logic [31:0] a);
        logic [31:0] t;
        t = a >> 2;
        return t[10:0];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  db;
        logic [31:0] da;
        logic [31:0] dd;
        logic        eig;
        logic        edg;
        logic        een;
        logic        ewe;
        logic        rmw;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [3:0] db, input logic [31:0] da, input logic [31:0] dd,
                                input logic eig, input logic edg, input logic een, input logic ewe,
                                input logic rmw);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.db = db; v.da = da; v.dd = dd;
        v.eig = eig; v.edg = edg; v.een = een; v.ewe = ewe; v.rmw = rmw;
        return v;
    endfunction

    logic [10:0] pend_idx;
    logic [31:0] pend_val;

    // Apply one vector for one cycle (called at posedge+1), check at the falling edge, update the model.
    task automatic apply(input vec_t v);
        logic [31:0] exp_a;
        logic [31:0] exp_wd;
        i_req = v.ir; i_addr = v.ia;
        d_req = v.dr; d_we = v.dw; d_be = v.db; d_addr = v.da; d_wdata = v.dd;
        @(negedge Clk);
        chk("i_gnt", {31'd0, i_gnt}, {31'd0, v.eig});
        chk("d_gnt", {31'd0, d_gnt}, {31'd0, v.edg});
        chk("mem_en", {31'd0, mem_en}, {31'd0, v.een});
        chk("mem_we", {31'd0, mem_we}, {31'd0, v.ewe});
        if (v.een) begin
            exp_a = {21'd0, v.rmw ? pend_idx : (v.eig ? idx(v.ia) : idx(v.da))};
            chk("mem_addr", {21'd0, mem_addr}, exp_a);
        end
        if (v.ewe) begin
            exp_wd = v.rmw ? pend_val : v.dd;
            chk("mem_wdata", mem_wdata, exp_wd);
        end
        if (v.eig) iq.push_back({32'(cyc_n + 1), ref_mem[idx(v.ia)]});
        if (v.edg) begin
            if (!v.dw) begin
                dq.push_back({32'(cyc_n + 1), ref_mem[idx(v.da)]});
            end else if (v.db == 4'hF) begin
                ref_mem[idx(v.da)] = v.dd;
            end else if (v.db != 4'h0) begin
                pend_idx = idx(v.da);
                pend_val = merge(ref_mem[idx(v.da)], v.dd, v.db);
            end
        end
        if (v.rmw) ref_mem[pend_idx] = pend_val;
        @(posedge Clk);
        #1;
    endtask

    vec_t tbl [15];
    vec_t idle_v;

    initial begin
        for (int k = 0; k < 2048; k++) begin
            sram[k]    = 32'hA000_0000 | k;
            ref_mem[k] = 32'hA000_0000 | k;
        end
        sram[5]    = 32'h1122_3344;
        ref_mem[5] = 32'h1122_3344;
        mem_rdata  = '0;

        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //           ir  ia            dr dw db     da            dd             eig edg een ewe rmw
        tbl[0]  = mk(1, 32'h0000_0000, 1, 0, 4'h0, 32'h0000_0020, 32'h0,         0, 1, 1, 0, 0);
        tbl[1]  = mk(1, 32'h0000_0000, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 0, 0);
        tbl[2]  = mk(1, 32'h0000_0004, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 0, 0);
        tbl[3]  = mk(1, 32'h0000_0008, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 0, 0);
        tbl[4]  = mk(1, 32'h0000_2006, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 0, 0);
        tbl[5]  = mk(0, 32'h0,         1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 1, 1, 0);
        tbl[6]  = mk(1, 32'h0000_000C, 1, 0, 4'h0, 32'h0000_0010, 32'h0,         0, 1, 1, 0, 0);
        tbl[7]  = mk(1, 32'h0000_000C, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 32'h0,         1, 1, 4'h0, 32'h0000_0010, 32'h0,         0, 1, 0, 0, 0);
        tbl[9]  = mk(0, 32'h0,         1, 0, 4'h0, 32'h0000_0010, 32'h0,         0, 1, 1, 0, 0);
        tbl[10] = mk(0, 32'h0,         1, 1, 4'h2, 32'h0000_0014, 32'h0000_AB00, 0, 1, 1, 0, 0);
        tbl[11] = mk(1, 32'h0000_0000, 1, 0, 4'h0, 32'h0000_0014, 32'h0,         0, 0, 1, 1, 1);
        tbl[12] = mk(1, 32'h0000_0000, 1, 0, 4'h0, 32'h0000_0014, 32'h0,         0, 1, 1, 0, 0);
        tbl[13] = mk(1, 32'h0000_0000, 0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 1, 0, 0);
        tbl[14] = idle_v;

        // Reset with both requesters active: every output stays low.
        Reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
        d_addr = 32'h0000_0040; d_wdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge Clk);
            chk("rst_i_gnt", {31'd0, i_gnt}, 0);
            chk("rst_d_gnt", {31'd0, d_gnt}, 0);
            chk("rst_i_rvalid", {31'd0, i_rvalid}, 0);
            chk("rst_d_rvalid", {31'd0, d_rvalid}, 0);
            chk("rst_mem_en", {31'd0, mem_en}, 0);
            chk("rst_mem_we", {31'd0, mem_we}, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        for (int r = 0; r < 15; r++) apply(tbl[r]);

        // Starvation: fetch forced through after four consecutive refusals, twice over.
        for (int k = 0; k < 10; k++) begin
            logic fw;
            fw = (k == 4) || (k == 9);
            apply(mk(1, 32'h0000_0040, 1, 0, 4'h0, 32'h0000_0044, 32'h0, fw, !fw, 1, 0, 0));
        end
        apply(idle_v);

        // Reset lands on the RMW write cycle: no write, target word untouched.
        apply(mk(0, 32'h0, 1, 1, 4'h1, 32'h0000_0018, 32'h0000_00FF, 0, 1, 1, 0, 0));
        Reset = 1'b1;
        d_req = 1'b0;
        @(negedge Clk);
        chk("rmw_rst_mem_we", {31'd0, mem_we}, 0);
        chk("rmw_rst_mem_en", {31'd0, mem_en}, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
`ifdef MEMARB_PERF_EN
        chk("perf_rmw_after_reset", perf_rmw, 0);
        chk("perf_i_stall_after_reset", perf_i_stall, 0);
`endif
        apply(idle_v);
        chk("sram_word6_unchanged", sram[6], 32'hA000_0006);
        apply(mk(0, 32'h0, 1, 0, 4'h0, 32'h0000_0018, 32'h0, 0, 1, 1, 0, 0));
        apply(idle_v);
        apply(idle_v);

        chk("sram_word4", sram[4], 32'hDEAD_BEEF);
        chk("sram_word5", sram[5], 32'h1122_AB44);
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
